board_debug_ctrl: RTL and testbench
===================================

BOARD_DEBUG_CTRL -- requirements
Module: board_debug_ctrl

Interface
REQ-001 Parameter NUM_VIEWS, default 7: number of selectable debug views, legal range 2..16.
REQ-002 Parameter DATA_W, default 32: width of each view and of the display word.
REQ-003 Parameter DEBOUNCE_CYC, default 250000: consecutive stable clk cycles required to accept a button level, minimum 2.
REQ-004 Parameter RUN_DIV, default 5000000: clk cycles between step pulses in run mode, minimum 2.
REQ-005 Derived SEL_W = clog2(NUM_VIEWS), minimum 1.
REQ-006 clk  input  1  board clock; all state is on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_step  input  1  raw, asynchronous push button: single-step request.
REQ-009 btn_next  input  1  raw button: select the next view.
REQ-010 btn_prev  input  1  raw button: select the previous view.
REQ-011 btn_mode  input  1  raw button: toggle between step mode and run mode.
REQ-012 view_data  input  NUM_VIEWS*DATA_W  flattened views; view k occupies bits [k*DATA_W +: DATA_W].
REQ-013 cpu_step  output  1  one-clk-wide clock-enable pulse for the target core.
REQ-014 run_mode  output  1  0 = STEP state, 1 = RUN state.
REQ-015 view_sel  output  SEL_W  currently selected view index.
REQ-016 disp_data  output  DATA_W  registered selected view, driven to the seven-segment driver.
REQ-017 step_count  output  16  number of cpu_step pulses issued since reset.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer and then an independent debouncer.
REQ-019 Debouncer: the debounced level SHALL take the synchronized value only after it has differed from the current debounced level for DEBOUNCE_CYC consecutive cycles; any bounce SHALL restart the count.
REQ-020 A press pulse SHALL be asserted for exactly one cycle on each 0->1 transition of a debounced level; releases SHALL produce no pulse.
REQ-021 A next pulse SHALL increment view_sel, wrapping from NUM_VIEWS-1 to 0.
REQ-022 A prev pulse SHALL decrement view_sel, wrapping from 0 to NUM_VIEWS-1.
REQ-023 When next and prev pulses occur in the same cycle, view_sel SHALL be unchanged.
REQ-024 disp_data SHALL equal the view_data slice indexed by view_sel, with 1 cycle of latency, tracking input changes every cycle.
REQ-025 FSM states SHALL be STEP and RUN; a mode pulse SHALL toggle the state and clear the run divider.
REQ-026 In STEP: a step pulse in cycle t SHALL produce cpu_step=1 in cycle t+1 only.
REQ-027 In RUN: the divider SHALL count 0..RUN_DIV-1, and cpu_step SHALL be 1 for the single cycle after the divider wraps; step pulses SHALL be ignored.
REQ-028 If mode and step pulses occur in the same cycle while in STEP, the step pulse SHALL be honoured and the state SHALL then move to RUN.
REQ-029 step_count SHALL increment on every cycle in which cpu_step=1, wrapping from 0xFFFF to 0.
REQ-030 cpu_step SHALL never be high for two consecutive cycles.

Reset
REQ-031 While rst_n=0, all of the following SHALL be 0 regardless of clk: cpu_step, run_mode, view_sel, disp_data, step_count, synchronizers, debounced levels, debounce counters and the run divider.
REQ-032 A reset mid-debounce or mid-divide SHALL discard partial counts; no press or step pulse SHALL be generated by the reset release itself.
REQ-033 After rst_n rises, disp_data SHALL show view 0 from the second clk edge.

Verification (NUM_VIEWS=7, DEBOUNCE_CYC=4, RUN_DIV=8)
REQ-034 Bench: btn_next held high for 3 cycles, low, then high for 10 cycles -> view_sel stays 0, then becomes 1; a single 1-cycle pulse is seen.
REQ-035 Bench: 7 clean next presses -> view_sel steps 1,2,...,6,0; a prev press from 0 -> 6; next and prev aligned -> no change.
REQ-036 Bench: view_data view 3 = 0x88888888 with view_sel=3 -> disp_data = 0x88888888 one cycle later; changing the input is tracked with 1-cycle lag.
REQ-037 Bench: STEP mode with 3 step presses -> exactly 3 single-cycle cpu_step pulses and step_count=3.
REQ-038 Bench: mode press then 40 cycles -> run_mode=1, cpu_step every 8 cycles (5 pulses), step presses ignored; a second mode press -> pulses stop.
REQ-039 Bench: rst_n low asynchronously mid-RUN with view_sel=4 and step_count=9 -> all outputs 0 immediately, with no cpu_step after release until a new press.

Source files
------------

// File: rtl/board_debug_ctrl.sv
// Board debug controller: debounced buttons step or free-run the target core
// and select which debug view is latched for the seven-segment display.
module board_debug_ctrl #(
    parameter int NUM_VIEWS    = 7,
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int RUN_DIV      = 5000000,
    localparam int SEL_W = (NUM_VIEWS > 2) ? $clog2(NUM_VIEWS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        btn_step,
    input  logic                        btn_next,
    input  logic                        btn_prev,
    input  logic                        btn_mode,
    input  logic [NUM_VIEWS*DATA_W-1:0] view_data,
    output logic                        cpu_step,
    output logic                        run_mode,
    output logic [SEL_W-1:0]            view_sel,
    output logic [DATA_W-1:0]           disp_data,
    output logic [15:0]                 step_count
);

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_VIEWS - 1);

    typedef enum logic {
        STEP = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Button bit order: 0 step, 1 next, 2 prev, 3 mode
    logic [3:0]            raw;
    logic [3:0]            sync1;
    logic [3:0]            sync2;
    logic [3:0]            deb;
    logic [3:0]            deb_d;
    logic [3:0]            press;
    logic [3:0][CNT_W-1:0] cnt;

    state_t                state;
    state_t                state_nx;
    logic [DIV_W-1:0]      div;
    logic                  step_fire;

    logic [DATA_W-1:0]     views [NUM_VIEWS];

    assign raw = {btn_mode, btn_prev, btn_next, btn_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A level is accepted only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_d <= '0;
            cnt   <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press = deb & ~deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            view_sel <= '0;
        end else if (press[1] && !press[2]) begin
            view_sel <= (view_sel == SEL_LAST) ? '0 : view_sel + SEL_W'(1);
        end else if (press[2] && !press[1]) begin
            view_sel <= (view_sel == '0) ? SEL_LAST : view_sel - SEL_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_VIEWS; k++) begin : g_view
        assign views[k] = view_data[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data <= '0;
        end else begin
            disp_data <= views[view_sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STEP;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (press[3]) begin
            state_nx = (state == STEP) ? RUN : STEP;
        end
    end

    // A wrap coinciding with a mode toggle is dropped, so leaving RUN is clean
    always_comb begin
        step_fire = 1'b0;
        unique case (state)
            STEP: step_fire = press[0];
            RUN:  step_fire = (div == DIV_LAST) && !press[3];
        endcase
        step_fire = step_fire && !cpu_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (press[3] || state != RUN || div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_step   <= 1'b0;
            step_count <= '0;
        end else begin
            cpu_step <= step_fire;
            if (cpu_step) begin
                step_count <= step_count + 16'd1;
            end
        end
    end

    assign run_mode = (state == RUN);

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Directed bench for board_debug_ctrl with short debounce and run periods.
module tb_board_debug_ctrl;

    localparam int NV = 7;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      btn = '0;
    logic [NV*DW-1:0] view_data = '0;
    logic            cpu_step;
    logic            run_mode;
    logic [2:0]      view_sel;
    logic [DW-1:0]   disp_data;
    logic [15:0]     step_count;

    logic [DW-1:0]   vd [NV];

    int n_chk = 0;
    int n_pass = 0;
    int pulses = 0;
    int doubles = 0;
    int cyc = 0;
    int last_pulse = 0;
    int gap = 0;
    logic prev_step = 1'b0;

    board_debug_ctrl #(
        .NUM_VIEWS(NV),
        .DATA_W(DW),
        .DEBOUNCE_CYC(4),
        .RUN_DIV(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_step(btn[0]),
        .btn_next(btn[1]),
        .btn_prev(btn[2]),
        .btn_mode(btn[3]),
        .view_data(view_data),
        .cpu_step(cpu_step),
        .run_mode(run_mode),
        .view_sel(view_sel),
        .disp_data(disp_data),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (cpu_step) begin
            pulses++;
            gap = cyc - last_pulse;
            last_pulse = cyc;
            if (prev_step) doubles++;
        end
        prev_step = cpu_step;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_views();
        for (int k = 0; k < NV; k++) view_data[k*DW +: DW] = vd[k];
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        tick(10);
        btn[b] = 1'b0;
        tick(10);
    endtask

    initial begin
        logic [2:0] prev_sel;
        int changes;
        int exp_sel;

        for (int k = 0; k < NV; k++) vd[k] = 32'hA000_0000 | k;
        apply_views();

        tick(3);
        chk("rst_view_sel", 32'(view_sel), 0);
        chk("rst_run_mode", 32'(run_mode), 0);
        chk("rst_cpu_step", 32'(cpu_step), 0);
        chk("rst_step_count", 32'(step_count), 0);
        chk("rst_disp", disp_data, 0);
        rst_n = 1'b1;
        tick(2);
        chk("disp_view0", disp_data, vd[0]);

        // short bounce is rejected, long hold gives one step of view_sel
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        tick(10);
        chk("bounce_no_change", 32'(view_sel), 0);
        changes = 0;
        prev_sel = view_sel;
        btn[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) btn[1] = 1'b0;
            tick(1);
            if (view_sel != prev_sel) changes++;
            prev_sel = view_sel;
        end
        chk("hold_single_press", changes, 1);
        chk("hold_view_sel", 32'(view_sel), 1);

        exp_sel = 1;
        for (int i = 0; i < 6; i++) begin
            press(1);
            exp_sel = (exp_sel + 1) % NV;
            chk("next_wrap", 32'(view_sel), exp_sel);
        end
        press(2);
        chk("prev_wrap", 32'(view_sel), 6);
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        tick(10);
        btn[1] = 1'b0;
        btn[2] = 1'b0;
        tick(10);
        chk("next_prev_cancel", 32'(view_sel), 6);
        press(2);
        press(2);
        press(2);
        chk("prev_to_3", 32'(view_sel), 3);
        chk("disp_view3", disp_data, vd[3]);

        vd[3] = 32'h8888_8888;
        apply_views();
        tick(1);
        chk("disp_88", disp_data, 32'h8888_8888);
        vd[3] = 32'h1234_5678;
        apply_views();
        #2;
        chk("disp_lag_old", disp_data, 32'h8888_8888);
        tick(1);
        chk("disp_lag_new", disp_data, 32'h1234_5678);

        pulses = 0;
        doubles = 0;
        press(0);
        press(0);
        press(0);
        chk("step_pulses", pulses, 3);
        chk("step_count3", 32'(step_count), 3);
        chk("step_single_cyc", doubles, 0);
        chk("step_mode_still", 32'(run_mode), 0);

        press(3);
        chk("run_mode_on", 32'(run_mode), 1);
        pulses = 0;
        press(0);
        press(0);
        chk("run_pulses_40", pulses, 5);
        chk("run_gap", gap, 8);
        chk("run_single_cyc", doubles, 0);
        press(3);
        chk("run_mode_off", 32'(run_mode), 0);
        pulses = 0;
        tick(30);
        chk("run_stopped", pulses, 0);

        // rebuild a known state, then reset asynchronously mid-RUN
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) press(0);
        for (int i = 0; i < 4; i++) press(1);
        press(3);
        chk("pre_rst_count", 32'(step_count), 9);
        chk("pre_rst_sel", 32'(view_sel), 4);
        chk("pre_rst_run", 32'(run_mode), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_run_mode", 32'(run_mode), 0);
        chk("arst_view_sel", 32'(view_sel), 0);
        chk("arst_count", 32'(step_count), 0);
        chk("arst_disp", disp_data, 0);
        chk("arst_cpu_step", 32'(cpu_step), 0);
        tick(3);
        rst_n = 1'b1;
        pulses = 0;
        tick(25);
        chk("post_rst_no_step", pulses, 0);
        chk("post_rst_count", 32'(step_count), 0);
        press(0);
        chk("post_rst_press", pulses, 1);
        chk("post_rst_count1", 32'(step_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
